// File: rtl/btn_event_ctrl.sv
// Five-button debouncer with sticky W1C press events, saturating press count and maskable irq.
// Latency: press seen 2+DEBOUNCE_CYCLES edges after first sample, irq one edge later; no backpressure, reads combinational.
module btn_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  button,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] addr_to_btn,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_to_bridge,
    output logic        irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT} state_t;

    logic [4:0]       sync1, sync2;
    state_t           state_q [5];
    state_t           state_d [5];
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];
    logic [4:0]       press_evt;
    logic [4:0]       level;

    logic [4:0]       pending_q;
    logic [4:0]       irq_en_q;
    logic [15:0]      count_q, count_d;
    logic [16:0]      count_sum;
    logic [2:0]       evt_cnt;
    logic [4:0]       w1c;
    logic             wr_en;
    logic             unused_bits;

    assign unused_bits = ^{addr_to_btn[31:4], addr_to_btn[1:0], wdata[31:5]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            press_evt[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (sync2[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = DOWN;
                        press_evt[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                DOWN: begin
                    if (!sync2[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2[i]) begin
                        state_d[i] = DOWN;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Debounced level is high for as long as the button is considered held.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            level[i] = (state_q[i] == DOWN) || (state_q[i] == RELEASE_WAIT);
        end
    end

    assign wr_en = sel & we;
    assign w1c   = (wr_en && addr_to_btn[3:2] == 2'd0) ? wdata[4:0] : 5'd0;

    // A COUNT write in an event cycle restarts the count from that cycle's events.
    always_comb begin
        evt_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            evt_cnt = evt_cnt + {2'b00, press_evt[i]};
        end
        count_sum = {1'b0, count_q} + {14'd0, evt_cnt};
        if (wr_en && addr_to_btn[3:2] == 2'd3) begin
            count_d = {13'd0, evt_cnt};
        end else if (count_sum[16]) begin
            count_d = 16'hFFFF;
        end else begin
            count_d = count_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            irq_en_q  <= '0;
            count_q   <= '0;
            irq       <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~w1c) | press_evt;
            if (wr_en && addr_to_btn[3:2] == 2'd2) begin
                irq_en_q <= wdata[4:0];
            end
            count_q <= count_d;
            irq     <= |(pending_q & irq_en_q);
        end
    end

    always_comb begin
        rdata_to_bridge = '0;
        if (sel) begin
            case (addr_to_btn[3:2])
                2'd0:    rdata_to_bridge[4:0]  = pending_q;
                2'd1:    rdata_to_bridge[4:0]  = level;
                2'd2:    rdata_to_bridge[4:0]  = irq_en_q;
                default: rdata_to_bridge[15:0] = count_q;
            endcase
        end
    end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Bus-attached controller for the 5-bit push-button peripheral. It synchronizes and debounces each raw button line with a per-button state machine, and latches press events into sticky write-1-to-clear pending bits. It also keeps a saturating press counter and raises a maskable interrupt. It sits behind the bus bridge and replaces raw edge sampling with CPU-visible, debounced event registers.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a press or release (legal range ≥1)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-button debounce counter (derived, do not override)

Ports:
clk  input  1  system clock, all flops on rising edge
rst_n  input  1  asynchronous, active-low reset
button  input  5  raw asynchronous button lines, 1 = pressed
sel  input  1  bridge select for this device
we  input  1  write strobe, qualified by sel
addr_to_btn  input  32  byte address; only [3:2] decoded, other bits ignored
wdata  input  32  write data
rdata_to_bridge  output  32  read data, combinational
irq  output  1  interrupt request, registered

Behaviour:
- Sync: 2-FF synchronizer per bit (sync1, sync2), reset 0. The FSM sees sync2 only.
- Per-button FSM, states IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT; reset IDLE, counter 0:
  - IDLE: sync2=1 -> PRESS_WAIT, counter<=0.
  - PRESS_WAIT: sync2=0 -> IDLE (bounce rejected, no event).
  - PRESS_WAIT: counter==DEBOUNCE_CYCLES-1 -> DOWN, level<=1, one-cycle press event.
  - PRESS_WAIT: otherwise counter++.
  - DOWN: sync2=0 -> RELEASE_WAIT, counter<=0.
  - RELEASE_WAIT: sync2=1 -> DOWN (no new event).
  - RELEASE_WAIT: counter==DEBOUNCE_CYCLES-1 -> IDLE, level<=0.
  - RELEASE_WAIT: otherwise counter++.
  - Release generates no event.
- Latency: raw rise first sampled at edge k, held stable -> PRESS_WAIT after edge k+2, DOWN/pending/level after edge k+2+DEBOUNCE_CYCLES. Release uses the same timing.
- Register map, addr_to_btn[3:2]:
  - 0 STATUS: [4:0] pending, RO except write-1-to-clear.
  - 1 LEVEL: [4:0] debounced levels, read-only, writes ignored.
  - 2 IRQ_EN: [4:0] mask, RW.
  - 3 COUNT: [15:0] total accepted presses; any write clears it.
  - Unused upper bits read 0.
- Reset values: pending, level, IRQ_EN, COUNT and irq are all 0.
- rdata_to_bridge = sel ? selected register : 32'h0. Reads have no side effects.
- Writes take effect at the clock edge where sel & we = 1.
- Simultaneous press event and W1C on the same bit: set wins, bit stays 1. W1C on other bits still applies.
- COUNT:
  - Adds popcount of the cycle's press events (0..5) and saturates at 16'hFFFF, no wrap.
  - Write to COUNT in the same cycle as events: COUNT <= popcount of that cycle's events.
- irq <= |(pending & IRQ_EN), evaluated on the current register values, so irq has one cycle of latency.
  - Clearing the mask or the pending bit drops irq one cycle later.
- Reset mid-debounce aborts all FSMs to IDLE with counters 0. A button held through rst_n deassertion is debounced as a fresh press and produces an event.
- Bounce pulses shorter than DEBOUNCE_CYCLES in either wait state never change level or pending.

Test Plan:
DEBOUNCE_CYCLES=4. Hold button=5'b00001 from edge 10 -> level[0]=1 and STATUS=32'h1 after edge 16, COUNT=1, irq stays 0 (mask 0).
DEBOUNCE_CYCLES=4. Toggle button[1] 1,0 every 2 cycles for 20 cycles, then 0 -> STATUS=0, LEVEL=0, COUNT=0 throughout.
Write IRQ_EN=5'h1F, press button[2] -> irq=1 one cycle after pending[2]=1. Write STATUS=32'h4 -> pending[2]=0 next edge, irq=0 one edge later.
Press buttons 0 and 3 on the same edge -> STATUS=32'h9, COUNT increments by 2. W1C 32'h1 issued on the cycle a new button[0] event sets -> bit 0 remains 1.
Preload COUNT near max by forcing 65535 presses (or use a shortened-count bench override) -> stays 16'hFFFF on further presses. Write COUNT with a simultaneous single event -> COUNT=1.
Assert rst_n=0 while button[4] is in PRESS_WAIT at counter 2, and hold button through deassertion -> all registers 0, then pending[4]=1 after edge deassert+2+4.
